hdlc_tx_controller: RTL and testbench
=====================================

HDLC_TX_CONTROLLER -- requirements
Module: hdlc_tx_controller

Interface
REQ-001 Parameter BUF_DEPTH, default 128, frame buffer depth in bytes (power of two, 2..256).
REQ-002 Clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 Tx_WrBuff  input  1  buffer write strobe, one byte per cycle high.
REQ-005 Tx_DataIn  input  8  byte written when Tx_WrBuff=1.
REQ-006 Tx_Enable  input  1  frame start request, sampled each cycle.
REQ-007 Tx_AbortFrame  input  1  abort request, acted on at its rising edge.
REQ-008 Tx  output  1  registered serial line.
REQ-009 Tx_ValidFrame  output  1  high while a frame is being sent.
REQ-010 Tx_AbortedTrans  output  1  one-cycle pulse, frame was aborted.
REQ-011 Tx_Done  output  1  one-cycle pulse, frame completed normally.
REQ-012 Tx_Full  output  1  buffer holds BUF_DEPTH bytes.
REQ-013 Tx_FrameSize  output  9  bytes currently in buffer (0..BUF_DEPTH).

Function
REQ-014 States SHALL be IDLE, START_FLAG, DATA, END_FLAG, ABORT_WAIT, ABORT_FLAG.
REQ-015 Writes SHALL be accepted only in IDLE with Tx_Full=0; writes when full or outside IDLE are dropped, count unchanged.
REQ-016 Tx_Full SHALL equal (Tx_FrameSize==BUF_DEPTH); Tx_FrameSize increments by 1 per accepted write, no wrap.
REQ-017 In IDLE Tx SHALL be 1 (mark idle).
REQ-018 Tx_Enable=1 in IDLE with Tx_FrameSize>0 SHALL enter START_FLAG next cycle; with Tx_FrameSize=0 it is ignored.
REQ-019 START_FLAG and END_FLAG SHALL each drive 8 cycles of 0,1,1,1,1,1,1,0 on Tx.
REQ-020 DATA SHALL send buffered bytes in write order, each LSB first, one bit per cycle.
REQ-021 DATA SHALL insert one 0 cycle after every five consecutive transmitted 1s; the data shifter stalls during the inserted 0.
REQ-022 The consecutive-ones counter SHALL clear on any transmitted 0 (data or inserted) and on entry to DATA.
REQ-023 After the last data bit (plus any trailing inserted 0) the FSM SHALL enter END_FLAG.
REQ-024 After END_FLAG the FSM SHALL return to IDLE, pulse Tx_Done for that cycle, and clear Tx_FrameSize to 0.
REQ-025 Tx_ValidFrame SHALL be 1 from the first START_FLAG cycle through the last END_FLAG cycle, else 0.
REQ-026 A rising edge of Tx_AbortFrame (0 at cycle t-1, 1 at t) in any state except ABORT_WAIT/ABORT_FLAG SHALL enter ABORT_WAIT at t+1.
REQ-027 ABORT_WAIT SHALL last 3 cycles (t+1..t+3) with Tx=1; ABORT_FLAG SHALL drive 0 at t+4 then 1 for t+5..t+11, then return to IDLE.
REQ-028 Tx_AbortedTrans SHALL pulse at t+1 only if Tx_ValidFrame=1 at t; Tx_ValidFrame SHALL be 0 from t+1.
REQ-029 Abort SHALL clear the buffer (Tx_FrameSize=0 at t+1); Tx_Done SHALL not pulse for an aborted frame.
REQ-030 Abort edges during ABORT_WAIT/ABORT_FLAG SHALL be ignored; Tx_Enable SHALL be ignored outside IDLE.
REQ-031 Simultaneous Tx_Enable and abort edge in IDLE: abort wins, no frame starts, no Tx_AbortedTrans.
REQ-032 Simultaneous Tx_WrBuff and Tx_Enable in IDLE: byte accepted and included in the frame.

Reset
REQ-033 Rst=1 SHALL immediately force IDLE, Tx=1, Tx_ValidFrame=0, Tx_AbortedTrans=0, Tx_Done=0, Tx_Full=0, Tx_FrameSize=0, ones counter 0, abort-edge register 0.
REQ-034 Rst asserted mid-frame SHALL discard the frame with no Tx_Done or Tx_AbortedTrans pulse.

Verification
REQ-035 Write 0x00, Tx_Enable -> Tx: 01111110, eight 0s, 01111110, then idle 1s; Tx_Done one pulse; Tx_FrameSize 1 -> 0.
REQ-036 Write 0xFF -> DATA bits 1,1,1,1,1,0(inserted),1,1,1 (9 cycles); both flags unstuffed.
REQ-037 Write BUF_DEPTH+1 bytes -> Tx_Full=1, Tx_FrameSize=BUF_DEPTH, last byte dropped.
REQ-038 Abort edge at cycle t mid-DATA -> Tx_AbortedTrans at t+1, Tx=1 t+1..t+3, 0 at t+4, 1 t+5..t+11, Tx_ValidFrame=0 from t+1, no Tx_Done.
REQ-039 Abort edge in IDLE -> abort flag at t+4..t+11, no Tx_AbortedTrans; Tx_Enable with empty buffer -> Tx stays 1.
REQ-040 Rst pulse mid-END_FLAG -> all outputs at reset values same cycle; next frame transmits normally.

Source files
------------

// File: rtl/hdlc_tx_controller.sv
// HDLC frame transmitter: buffers up to BUF_DEPTH bytes, then sends an opening flag,
// the bit-stuffed payload LSB first and a closing flag; an abort edge sends an abort sequence.
module hdlc_tx_controller #(
  parameter int BUF_DEPTH = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_WrBuff,
  input  logic [7:0] Tx_DataIn,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done,
  output logic       Tx_Full,
  output logic [8:0] Tx_FrameSize
);

  localparam int         AW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [8:0] DEPTH_C = 9'(BUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_FLAG = 3'd1,
    DATA       = 3'd2,
    END_FLAG   = 3'd3,
    ABORT_WAIT = 3'd4,
    ABORT_FLAG = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [2:0] ones_q, ones_d;
  logic       stuff_q, stuff_d;
  logic [8:0] rd_q, rd_d;
  logic [8:0] cnt_q, cnt_d;
  logic       abort_prev_q;
  logic       tx_q, tx_d;
  logic       valid_q, valid_d;
  logic       aborted_q, aborted_d;
  logic       done_q, done_d;
  logic [7:0] mem_q [BUF_DEPTH];

  logic       abort_edge_s;
  logic       wr_ok_s;
  logic       cur_bit_s;
  logic [2:0] ones_nx_s;

  // Flag pattern 0,1,1,1,1,1,1,0 indexed by bit position.
  function automatic logic flag_bit(input logic [2:0] pos);
    return (pos != 3'd0) && (pos != 3'd7);
  endfunction

  assign Tx              = tx_q;
  assign Tx_ValidFrame   = valid_q;
  assign Tx_AbortedTrans = aborted_q;
  assign Tx_Done         = done_q;
  assign Tx_FrameSize    = cnt_q;
  assign Tx_Full         = (cnt_q == DEPTH_C);

  // Edge detect, write qualification and the bit currently on the line in DATA.
  always_comb begin
    abort_edge_s = Tx_AbortFrame & ~abort_prev_q;
    wr_ok_s      = (state_q == IDLE) && Tx_WrBuff && !Tx_Full;
    cur_bit_s    = stuff_q ? 1'b0 : mem_q[rd_q[AW-1:0]][bit_q];
    ones_nx_s    = cur_bit_s ? (ones_q + 3'd1) : 3'd0;
  end

  // Next-state logic; abort edge takes priority over everything outside the abort states.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    ones_d    = ones_q;
    stuff_d   = stuff_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    aborted_d = 1'b0;
    done_d    = 1'b0;
    if (abort_edge_s && (state_q != ABORT_WAIT) && (state_q != ABORT_FLAG)) begin
      state_d   = ABORT_WAIT;
      bit_d     = 3'd0;
      ones_d    = 3'd0;
      stuff_d   = 1'b0;
      rd_d      = 9'd0;
      cnt_d     = 9'd0;
      aborted_d = valid_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_ok_s) begin
            cnt_d = cnt_q + 9'd1;
          end else begin
            cnt_d = cnt_q;
          end
          if (Tx_Enable && (cnt_d != 9'd0)) begin
            state_d = START_FLAG;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
        START_FLAG: begin
          if (bit_q == 3'd7) begin
            state_d = DATA;
            bit_d   = 3'd0;
            ones_d  = 3'd0;
            stuff_d = 1'b0;
            rd_d    = 9'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        DATA: begin
          ones_d  = ones_nx_s;
          stuff_d = (ones_nx_s == 3'd5);
          // The shifter only advances on real data bits, never on an inserted zero.
          if (!stuff_q) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rd_d = rd_q + 9'd1;
            end else begin
              rd_d = rd_q;
            end
          end else begin
            bit_d = bit_q;
            rd_d  = rd_q;
          end
          if (!stuff_d && (rd_d == cnt_q)) begin
            state_d = END_FLAG;
            bit_d   = 3'd0;
            ones_d  = 3'd0;
          end else begin
            state_d = DATA;
          end
        end
        END_FLAG: begin
          if (bit_q == 3'd7) begin
            state_d = IDLE;
            bit_d   = 3'd0;
            cnt_d   = 9'd0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        ABORT_WAIT: begin
          if (bit_q == 3'd2) begin
            state_d = ABORT_FLAG;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        ABORT_FLAG: begin
          if (bit_q == 3'd7) begin
            state_d = IDLE;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          bit_d   = 3'd0;
        end
      endcase
    end
  end

  // Line value and frame-valid for the upcoming cycle, so both are registered yet aligned to the state.
  always_comb begin
    valid_d = (state_d == START_FLAG) || (state_d == DATA) || (state_d == END_FLAG);
    case (state_d)
      START_FLAG: tx_d = flag_bit(bit_d);
      END_FLAG:   tx_d = flag_bit(bit_d);
      DATA:       tx_d = stuff_d ? 1'b0 : mem_q[rd_d[AW-1:0]][bit_d];
      ABORT_FLAG: tx_d = (bit_d != 3'd0);
      default:    tx_d = 1'b1;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      bit_q        <= 3'd0;
      ones_q       <= 3'd0;
      stuff_q      <= 1'b0;
      rd_q         <= 9'd0;
      cnt_q        <= 9'd0;
      abort_prev_q <= 1'b0;
      tx_q         <= 1'b1;
      valid_q      <= 1'b0;
      aborted_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      ones_q       <= ones_d;
      stuff_q      <= stuff_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      abort_prev_q <= Tx_AbortFrame;
      tx_q         <= tx_d;
      valid_q      <= valid_d;
      aborted_q    <= aborted_d;
      done_q       <= done_d;
    end
  end

  // Frame buffer storage; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (wr_ok_s) begin
      mem_q[cnt_q[AW-1:0]] <= Tx_DataIn;
    end
  end

endmodule

// File: tb/tb_hdlc_tx_controller.sv
// Directed bench for hdlc_tx_controller: hand-computed line streams, abort sequences,
// buffer-full behaviour and asynchronous reset in mid-frame.
module tb_hdlc_tx_controller;

  localparam int DEPTH = 8;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tx_WrBuff;
  logic [7:0] Tx_DataIn;
  logic       Tx_Enable;
  logic       Tx_AbortFrame;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;
  logic       Tx_Full;
  logic [8:0] Tx_FrameSize;

  int n_vec = 0;
  int n_bad = 0;

  hdlc_tx_controller #(.BUF_DEPTH(DEPTH)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Tx_WrBuff       (Tx_WrBuff),
    .Tx_DataIn       (Tx_DataIn),
    .Tx_Enable       (Tx_Enable),
    .Tx_AbortFrame   (Tx_AbortFrame),
    .Tx              (Tx),
    .Tx_ValidFrame   (Tx_ValidFrame),
    .Tx_AbortedTrans (Tx_AbortedTrans),
    .Tx_Done         (Tx_Done),
    .Tx_Full         (Tx_Full),
    .Tx_FrameSize    (Tx_FrameSize)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    Tx_WrBuff = 1'b1;
    Tx_DataIn = b;
    step();
    Tx_WrBuff = 1'b0;
  endtask

  // Walk a line stream given as a '0'/'1' string, one character per cycle.
  task automatic check_stream(input string tag, input string bits, input logic vexp,
                              input logic [8:0] sexp);
    for (int i = 0; i < bits.len(); i++) begin
      chk({tag, "_tx"}, 32'(Tx), 32'(bits.getc(i) == "1"));
      chk({tag, "_valid"}, 32'(Tx_ValidFrame), 32'(vexp));
      chk({tag, "_size"}, 32'(Tx_FrameSize), 32'(sexp));
      chk({tag, "_done"}, 32'(Tx_Done), 32'd0);
      step();
    end
  endtask

  task automatic finish_frame(input string tag);
    chk({tag, "_donepulse"}, 32'(Tx_Done), 32'd1);
    chk({tag, "_idletx"}, 32'(Tx), 32'd1);
    chk({tag, "_idlevalid"}, 32'(Tx_ValidFrame), 32'd0);
    chk({tag, "_cleared"}, 32'(Tx_FrameSize), 32'd0);
    step();
    chk({tag, "_doneonce"}, 32'(Tx_Done), 32'd0);
  endtask

  // Caller drives the rising abort edge in the current cycle t.
  task automatic check_abort(input string tag, input logic aexp, input logic retrig);
    string pat;
    pat = "11101111111";
    step();
    chk({tag, "_aborted"}, 32'(Tx_AbortedTrans), 32'(aexp));
    for (int i = 0; i < pat.len(); i++) begin
      chk({tag, "_tx"}, 32'(Tx), 32'(pat.getc(i) == "1"));
      chk({tag, "_valid"}, 32'(Tx_ValidFrame), 32'd0);
      chk({tag, "_size"}, 32'(Tx_FrameSize), 32'd0);
      chk({tag, "_done"}, 32'(Tx_Done), 32'd0);
      if (i > 0) chk({tag, "_abortonce"}, 32'(Tx_AbortedTrans), 32'd0);
      if (retrig && i == 5) Tx_AbortFrame = 1'b0;
      if (retrig && i == 6) Tx_AbortFrame = 1'b1;
      step();
    end
    chk({tag, "_backidle"}, 32'(Tx), 32'd1);
  endtask

  initial begin
    Rst = 1'b1;
    Tx_WrBuff = 1'b0;
    Tx_DataIn = 8'h00;
    Tx_Enable = 1'b0;
    Tx_AbortFrame = 1'b0;
    step();
    chk("rst_tx", 32'(Tx), 32'd1);
    chk("rst_valid", 32'(Tx_ValidFrame), 32'd0);
    chk("rst_full", 32'(Tx_Full), 32'd0);
    chk("rst_size", 32'(Tx_FrameSize), 32'd0);
    chk("rst_done", 32'(Tx_Done), 32'd0);
    chk("rst_aborted", 32'(Tx_AbortedTrans), 32'd0);
    step();
    Rst = 1'b0;
    step();

    // Single 0x00 byte: no stuffing anywhere.
    write_byte(8'h00);
    chk("z_size1", 32'(Tx_FrameSize), 32'd1);
    Tx_Enable = 1'b1;
    step();
    Tx_Enable = 1'b0;
    check_stream("z", {"01111110", "00000000", "01111110"}, 1'b1, 9'd1);
    finish_frame("z");

    // 0xFF with writes and enables held throughout the frame (must be ignored).
    write_byte(8'hFF);
    Tx_Enable = 1'b1;
    step();
    Tx_WrBuff = 1'b1;
    Tx_DataIn = 8'h55;
    check_stream("ff", {"01111110", "111110111", "01111110"}, 1'b1, 9'd1);
    Tx_WrBuff = 1'b0;
    Tx_Enable = 1'b0;
    finish_frame("ff");

    // Three bytes, last written together with Tx_Enable; stuffing across a byte boundary and trailing.
    write_byte(8'hE0);
    write_byte(8'h03);
    Tx_WrBuff = 1'b1;
    Tx_DataIn = 8'hF8;
    Tx_Enable = 1'b1;
    step();
    Tx_WrBuff = 1'b0;
    Tx_Enable = 1'b0;
    check_stream("mb", {"01111110", "00000111", "110", "000000", "00011111", "0", "01111110"},
                 1'b1, 9'd3);
    finish_frame("mb");

    // Abort in the middle of DATA, with an ignored re-trigger during the abort flag.
    write_byte(8'h00);
    write_byte(8'h00);
    Tx_Enable = 1'b1;
    step();
    Tx_Enable = 1'b0;
    check_stream("pre", {"01111110", "000"}, 1'b1, 9'd2);
    Tx_AbortFrame = 1'b1;
    check_abort("abd", 1'b1, 1'b1);
    Tx_AbortFrame = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abd_nodone", 32'(Tx_Done), 32'd0);
      chk("abd_quiet", 32'(Tx), 32'd1);
    end

    // Fill beyond capacity: the extra byte is dropped.
    for (int i = 0; i <= DEPTH; i++) begin
      write_byte(8'(i));
      chk("fill_size", 32'(Tx_FrameSize), (i < DEPTH) ? 32'(i + 1) : 32'(DEPTH));
      chk("fill_full", 32'(Tx_Full), (i + 1 >= DEPTH) ? 32'd1 : 32'd0);
    end

    // Abort edge together with Tx_Enable in IDLE: abort wins and flushes the buffer.
    Tx_Enable = 1'b1;
    Tx_AbortFrame = 1'b1;
    check_abort("abi", 1'b0, 1'b0);
    Tx_AbortFrame = 1'b0;
    chk("abi_notfull", 32'(Tx_Full), 32'd0);
    // Tx_Enable still high with an empty buffer: line stays idle.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("empty_tx", 32'(Tx), 32'd1);
      chk("empty_valid", 32'(Tx_ValidFrame), 32'd0);
    end
    Tx_Enable = 1'b0;
    step();

    // Reset in the middle of the closing flag.
    write_byte(8'h00);
    Tx_Enable = 1'b1;
    step();
    Tx_Enable = 1'b0;
    check_stream("rpre", {"01111110", "00000000", "011"}, 1'b1, 9'd1);
    Rst = 1'b1;
    #2;
    chk("mrst_tx", 32'(Tx), 32'd1);
    chk("mrst_valid", 32'(Tx_ValidFrame), 32'd0);
    chk("mrst_size", 32'(Tx_FrameSize), 32'd0);
    chk("mrst_done", 32'(Tx_Done), 32'd0);
    chk("mrst_aborted", 32'(Tx_AbortedTrans), 32'd0);
    step();
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_nodone", 32'(Tx_Done), 32'd0);
      chk("mrst_noabort", 32'(Tx_AbortedTrans), 32'd0);
    end

    // Next frame after reset transmits normally.
    write_byte(8'hFF);
    Tx_Enable = 1'b1;
    step();
    Tx_Enable = 1'b0;
    check_stream("post", {"01111110", "111110111", "01111110"}, 1'b1, 9'd1);
    finish_frame("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
